// File: rtl/iiitb_bc_pkg.sv
// Shared definitions for the parametrised binary counter: mode/direction
// encodings and the next-count arithmetic used by the top level.
package iiitb_bc_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

  // One bit wider than the largest supported counter so count+STEP never truncates.
  localparam int WIDE_W = 33;
  typedef logic [WIDE_W-1:0] wide_t;
  localparam wide_t W_ZERO = '0;
  localparam wide_t W_ONE  = wide_t'(1);

  typedef struct packed {
    logic  tc;
    wide_t value;
  } bc_result_t;

  // tc flags any tick whose unclamped result leaves 0..max_val, in either mode.
  function automatic bc_result_t bc_next(
    input wide_t count,
    input wide_t step,
    input wide_t max_val,
    input logic  dir,
    input logic  mode
  );
    bc_result_t r;
    wide_t      sum;
    r.tc    = 1'b0;
    r.value = count;
    sum     = count + step;
    if (dir == DIR_UP) begin
      if (sum <= max_val) begin
        r.value = sum;
      end else begin
        r.tc    = 1'b1;
        r.value = (mode == MODE_SAT) ? max_val : (sum - max_val - W_ONE);
      end
    end else begin
      if (count >= step) begin
        r.value = count - step;
      end else begin
        r.tc    = 1'b1;
        r.value = (mode == MODE_SAT) ? W_ZERO : (count + max_val + W_ONE - step);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/iiitb_bc_if.sv
// Control and status bundle between the counter and its host logic.
interface iiitb_bc_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             up_down;
  logic             mode;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             ovf_clr;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ovf;

  modport master (
    output en, up_down, mode, clr, load, load_val, ovf_clr,
    input  count, tc, ovf
  );

  modport slave (
    input  en, up_down, mode, clr, load, load_val, ovf_clr,
    output count, tc, ovf
  );
endinterface

// File: rtl/iiitb_bc_prescaler.sv
// Enable divider: one tick per PRESC enabled cycles; sync_clr restarts the phase.
module iiitb_bc_prescaler #(
  parameter int unsigned PRESC = 1
) (
  input  logic Clk,
  input  logic reset_n,
  input  logic en,
  input  logic sync_clr,
  output logic tick
);

  generate
    if (PRESC <= 1) begin : g_bypass
      logic unused_in;
      assign unused_in = ^{Clk, reset_n, sync_clr};
      assign tick      = en;
    end else begin : g_div
      localparam int PW = $clog2(PRESC);
      localparam logic [PW-1:0] P_LAST = PW'(PRESC - 1);
      localparam logic [PW-1:0] P_ONE  = PW'(1);

      logic [PW-1:0] p_reg;
      logic [PW-1:0] p_next;

      always_comb begin
        p_next = p_reg;
        if (sync_clr) begin
          p_next = '0;
        end else if (en) begin
          p_next = (p_reg == P_LAST) ? '0 : (p_reg + P_ONE);
        end
      end

      always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
          p_reg <= '0;
        end else begin
          p_reg <= p_next;
        end
      end

      assign tick = en && (p_reg == P_LAST);
    end
  endgenerate

endmodule

// File: rtl/iiitb_bc_param.sv
// Parametrised up/down counter with wrap/saturate, load/clear, prescaled
// enable, registered terminal-count pulse and sticky overflow flag.
module iiitb_bc_param
  import iiitb_bc_pkg::*;
#(
  parameter int unsigned       WIDTH   = 4,
  parameter longint unsigned   MAX_VAL = (64'd1 << WIDTH) - 64'd1,
  parameter longint unsigned   STEP    = 1,
  parameter int unsigned       PRESC   = 1
) (
  input  logic       Clk,
  input  logic       reset_n,
  iiitb_bc_if.slave  bus
);

  localparam wide_t MAX_W  = wide_t'(MAX_VAL);
  localparam wide_t STEP_W = wide_t'(STEP);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic             tc_reg;
  logic             tc_next;
  logic             ovf_reg;
  logic             ovf_next;
  logic             tick;
  bc_result_t       arith;
  logic             unused_hi;

  iiitb_bc_prescaler #(
    .PRESC (PRESC)
  ) u_presc (
    .Clk      (Clk),
    .reset_n  (reset_n),
    .en       (bus.en),
    .sync_clr (bus.clr | bus.load),
    .tick     (tick)
  );

  assign arith     = bc_next(wide_t'(count_reg), STEP_W, MAX_W, bus.up_down, bus.mode);
  assign unused_hi = ^arith.value[WIDE_W-1:WIDTH];

  // clr > load > tick > hold; tc only ever comes from a tick.
  always_comb begin
    count_next = count_reg;
    tc_next    = 1'b0;
    if (bus.clr) begin
      count_next = '0;
    end else if (bus.load) begin
      count_next = (wide_t'(bus.load_val) > MAX_W) ? MAX_W[WIDTH-1:0] : bus.load_val;
    end else if (tick) begin
      count_next = arith.value[WIDTH-1:0];
      tc_next    = arith.tc;
    end
  end

  // A new overflow beats a simultaneous clear request.
  always_comb begin
    ovf_next = ovf_reg;
    if (tc_next) begin
      ovf_next = 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_next = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
      tc_reg    <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      tc_reg    <= tc_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign bus.count = count_reg;
  assign bus.tc    = tc_reg;
  assign bus.ovf   = ovf_reg;

endmodule

// File: tb/tb_iiitb_bc_param.sv
// Directed bench over four counter configurations with an expectation queue.
module tb_iiitb_bc_param;

  logic       Clk;
  logic       reset_n;
  logic       en, up_down, mode, clr, load, ovf_clr;
  logic [3:0] load_val;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string tag;
    int    dut;
    int    count;
    bit    tc;
    bit    ovf;
    bit    chk_ovf;
  } exp_t;

  exp_t sb[$];

  logic [3:0] cnt_obs [4];
  logic       tc_obs  [4];
  logic       ovf_obs [4];

  iiitb_bc_if #(.WIDTH(4)) bus [4] ();

  // a: wrap 0..9 step 1, b: 0..9 step 3, c: 0..15 step 1, d: 0..15 prescaled by 4
  iiitb_bc_param #(.WIDTH(4), .MAX_VAL(9),  .STEP(1), .PRESC(1)) u_a (.Clk(Clk), .reset_n(reset_n), .bus(bus[0]));
  iiitb_bc_param #(.WIDTH(4), .MAX_VAL(9),  .STEP(3), .PRESC(1)) u_b (.Clk(Clk), .reset_n(reset_n), .bus(bus[1]));
  iiitb_bc_param #(.WIDTH(4), .MAX_VAL(15), .STEP(1), .PRESC(1)) u_c (.Clk(Clk), .reset_n(reset_n), .bus(bus[2]));
  iiitb_bc_param #(.WIDTH(4), .MAX_VAL(15), .STEP(1), .PRESC(4)) u_d (.Clk(Clk), .reset_n(reset_n), .bus(bus[3]));

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_bus
      assign bus[gi].en       = en;
      assign bus[gi].up_down  = up_down;
      assign bus[gi].mode     = mode;
      assign bus[gi].clr      = clr;
      assign bus[gi].load     = load;
      assign bus[gi].load_val = load_val;
      assign bus[gi].ovf_clr  = ovf_clr;
      assign cnt_obs[gi]      = bus[gi].count;
      assign tc_obs[gi]       = bus[gi].tc;
      assign ovf_obs[gi]      = bus[gi].ovf;
    end
  endgenerate

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push(input int dut, input string tag, input int c, input bit t, input bit o, input bit co);
    exp_t e;
    e.tag = tag; e.dut = dut; e.count = c; e.tc = t; e.ovf = o; e.chk_ovf = co;
    sb.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cmp({e.tag, ".count"}, 32'(cnt_obs[e.dut]), 32'(e.count));
      cmp({e.tag, ".tc"}, 32'(tc_obs[e.dut]), 32'(e.tc));
      if (e.chk_ovf) cmp({e.tag, ".ovf"}, 32'(ovf_obs[e.dut]), 32'(e.ovf));
      $display("txn %-16s dut=%0d count=%0d tc=%0b ovf=%0b", e.tag, e.dut,
               cnt_obs[e.dut], tc_obs[e.dut], ovf_obs[e.dut]);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
    check_now();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; en = 1'b0; up_down = 1'b1; mode = 1'b0;
    clr = 1'b0; load = 1'b0; load_val = 4'd0; ovf_clr = 1'b0;

    for (int d = 0; d < 4; d++) push(d, "reset", 0, 1'b0, 1'b0, 1'b1);
    step();
    reset_n = 1'b1;

    // wrap up on a: 1..9 then 0 with tc/ovf
    en = 1'b1; up_down = 1'b1; mode = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      push(0, $sformatf("a_up%0d", i), i % 10, i == 10, i == 10, 1'b1);
      step();
    end
    en = 1'b0;
    push(0, "a_hold", 0, 1'b0, 1'b1, 1'b1);
    step();

    en = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      push(0, $sformatf("a_to6_%0d", i), i, 1'b0, 1'b1, 1'b1);
      step();
    end
    en = 1'b0;

    // asynchronous reset between edges
    #2;
    reset_n = 1'b0;
    #1;
    push(0, "a_async_rst", 0, 1'b0, 1'b0, 1'b1);
    check_now();
    #1;
    reset_n = 1'b1;
    push(0, "a_post_rst", 0, 1'b0, 1'b0, 1'b1);
    step();

    // overflow set beats ovf_clr on the same edge
    load = 1'b1; load_val = 4'd9;
    push(0, "a_load9", 9, 1'b0, 1'b0, 1'b1);
    step();
    load = 1'b0; en = 1'b1; ovf_clr = 1'b1;
    push(0, "a_set_wins", 0, 1'b1, 1'b1, 1'b1);
    step();
    en = 1'b0;
    push(0, "a_ovf_clr", 0, 1'b0, 1'b0, 1'b1);
    step();
    ovf_clr = 1'b0;

    // priority and load clamp
    load = 1'b1; load_val = 4'd5;
    push(0, "a_load5", 5, 1'b0, 1'b0, 1'b1);
    step();
    clr = 1'b1; load_val = 4'd7; en = 1'b1;
    push(0, "a_clr_prio", 0, 1'b0, 1'b0, 1'b1);
    step();
    clr = 1'b0; load_val = 4'd12;
    push(0, "a_load_clamp", 9, 1'b0, 1'b0, 1'b1);
    step();
    load = 1'b0; en = 1'b0;

    // wrap down on b, step 3
    load = 1'b1; load_val = 4'd1;
    push(1, "b_load1", 1, 1'b0, 1'b0, 1'b0);
    step();
    load = 1'b0; en = 1'b1; up_down = 1'b0; mode = 1'b0;
    push(1, "b_down_wrap", 8, 1'b1, 1'b1, 1'b1);
    step();
    push(1, "b_down", 5, 1'b0, 1'b1, 1'b1);
    step();
    en = 1'b0;

    // saturate on c
    load = 1'b1; load_val = 4'd14; up_down = 1'b1; mode = 1'b1;
    push(2, "c_load14", 14, 1'b0, 1'b0, 1'b0);
    step();
    load = 1'b0; en = 1'b1;
    push(2, "c_sat1", 15, 1'b0, 1'b0, 1'b0);
    step();
    push(2, "c_sat2", 15, 1'b1, 1'b1, 1'b1);
    step();
    push(2, "c_sat3", 15, 1'b1, 1'b1, 1'b1);
    step();
    up_down = 1'b0;
    push(2, "c_down", 14, 1'b0, 1'b1, 1'b1);
    step();
    en = 1'b0;

    // prescaler by 4 on d
    clr = 1'b1; mode = 1'b0; up_down = 1'b1;
    push(3, "d_clr", 0, 1'b0, 1'b0, 1'b0);
    step();
    clr = 1'b0; en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      push(3, $sformatf("d_presc%0d", k), k / 4, 1'b0, 1'b0, 1'b0);
      step();
    end
    for (int k = 1; k <= 6; k++) begin
      en = (k == 3 || k == 4) ? 1'b0 : 1'b1;
      push(3, $sformatf("d_gap%0d", k), (k == 6) ? 4 : 3, 1'b0, 1'b0, 1'b0);
      step();
    end
    en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
